// File: rtl/obi_data_mem_responder.sv
// Memory-side responder for the core's req/gnt/rvalid data port: delayed grant, byte-enabled
// writes, fixed-latency in-order responses. Define OBI_MEM_RESP_ERR_EN to add err_o for out-of-range addresses.
module obi_data_mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 256,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
`ifdef OBI_MEM_RESP_ERR_EN
    output logic        err_o,
`endif
    output logic [31:0] rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } resp_t;

    state_e                   state;
    logic [DW-1:0]            wait_cnt;
    logic [CW-1:0]            out_cnt;
    resp_t [RESP_LATENCY-1:0] pipe;
    resp_t                    push;
    logic                     delay_ok;
    logic                     blocked;
    logic                     oor;
    logic                     wr_en;
    logic [AW-1:0]            idx;
    logic [31:0]              mem [DEPTH_WORDS];
    logic                     unused_addr;

    assign idx         = addr_i[AW+1:2];
    assign unused_addr = ^addr_i;

`ifdef OBI_MEM_RESP_ERR_EN
    assign oor = {2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS);
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        delay_ok = 1'b0;
        if (GNT_DELAY == 0)
            delay_ok = 1'b1;
        else if (state == S_WAIT && wait_cnt == DW'(GNT_DELAY))
            delay_ok = 1'b1;
    end

    // A response leaving the pipe this cycle frees its slot for a same-cycle grant.
    assign blocked = (out_cnt == CW'(MAX_OUTSTANDING)) && !rvalid_o;
    assign gnt_o   = rst_ni && req_i && delay_ok && !blocked;
    assign wr_en   = gnt_o && we_i && !oor;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else if (GNT_DELAY != 0) begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        state    <= S_WAIT;
                        wait_cnt <= DW'(1);
                    end
                end
                S_WAIT: begin
                    if (!req_i || gnt_o) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt != DW'(GNT_DELAY)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        push      = '0;
        push.vld  = gnt_o;
        push.err  = gnt_o && oor;
        push.data = (gnt_o && !we_i && !oor) ? mem[idx] : 32'h0;
    end

    // Idle slots carry zero data so rdata_o is 0 whenever rvalid_o is low.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe <= '0;
        end else begin
            pipe[0] <= push;
            for (int i = 1; i < RESP_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign rvalid_o = pipe[RESP_LATENCY-1].vld;
    assign rdata_o  = pipe[RESP_LATENCY-1].data;
`ifdef OBI_MEM_RESP_ERR_EN
    assign err_o    = pipe[RESP_LATENCY-1].err;
`endif

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt <= '0;
        end else begin
            case ({gnt_o, rvalid_o})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule
